// File: rtl/regmst_apb_mux.sv
// APB slave to SLV_NUM reg_native_if masters. Address-window decode, ack watchdog,
// PSLVERR on decode miss or timeout, and a sticky error interrupt.
module regmst_apb_mux #(
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SLV_NUM        = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WIN_BITS       = 12,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic [SLV_NUM-1:0]            req_vld,
  input  logic [SLV_NUM-1:0]            ack_vld,
  output logic                          wr_en,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] rd_data,
  input  logic                          clear,
  output logic                          interrupt
);

  localparam int IDX_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // One extra bit so SLV_NUM << WIN_BITS cannot overflow the compare.
  localparam logic [ADDR_WIDTH:0]  SPAN    = (ADDR_WIDTH+1)'(SLV_NUM) << WIN_BITS;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                           state;
  logic [CNT_W-1:0]                     cnt;
  logic [IDX_W-1:0]                     sel_idx;
  logic [ADDR_WIDTH-1:0]                off;
  logic                                 hit;
  logic [IDX_W-1:0]                     dec_idx;
  logic [SLV_NUM-1:0]                   dec_oh;
  logic [SLV_NUM-1:0][DATA_WIDTH-1:0]   rd_vec;
  logic                                 ack_sel;
  logic                                 setup;
  logic                                 tmo;
  logic                                 set_err;

  assign off     = PADDR - BASE_ADDR;
  assign hit     = (PADDR >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign dec_idx = IDX_W'(off >> WIN_BITS);

  for (genvar k = 0; k < SLV_NUM; k++) begin : g_dec
    assign dec_oh[k] = (dec_idx == IDX_W'(k));
  end

  assign rd_vec  = rd_data;
  assign ack_sel = ack_vld[sel_idx];
  assign setup   = (state == S_IDLE) && PSEL && !PENABLE;
  assign tmo     = (state == S_WAIT) && !ack_sel && (cnt == CNT_MAX);
  assign set_err = (setup && !hit) || tmo;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      sel_idx <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      req_vld <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      addr    <= '0;
      wr_data <= '0;
    end else begin
      req_vld <= '0;
      case (state)
        S_IDLE: begin
          if (setup) begin
            sel_idx <= dec_idx;
            if (hit) begin
              req_vld <= dec_oh;
              wr_en   <= PWRITE;
              rd_en   <= !PWRITE;
              addr    <= PADDR;
              wr_data <= PWDATA;
              state   <= S_WAIT;
            end else begin
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              PRDATA  <= '0;
              state   <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          // Ack beats timeout when both land on the same edge.
          if (ack_sel) begin
            PREADY  <= 1'b1;
            PSLVERR <= 1'b0;
            PRDATA  <= rd_en ? rd_vec[sel_idx] : '0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            cnt     <= '0;
            state   <= S_RESP;
          end else if (cnt == CNT_MAX) begin
            PREADY  <= 1'b1;
            PSLVERR <= 1'b1;
            PRDATA  <= '0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            cnt     <= '0;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
          cnt     <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error on the clearing edge keeps it set.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)     interrupt <= 1'b0;
    else if (set_err) interrupt <= 1'b1;
    else if (clear)   interrupt <= 1'b0;
  end

endmodule
